// File: rtl/zigzag_rle_if.sv
// zigzag_rle_if: block-in / symbol-out bundle for the zig-zag run-length encoder.
//   A           quantized 8x8 block, coefficient (i,j) at A[(i*8+j)*COEF_W +: COEF_W]
//   in_valid    A holds a complete block           in_ready   encoder can take a block
//   out_valid   symbol is presented                out_ready  consumer takes the symbol
//   out_run     zero-run before the level          out_level  signed level, COEF_W+1 bits
//   out_eob     symbol is End-Of-Block             block_done pulse after the last symbol
// Modports: slave = encoder side, master = producer/consumer side.
interface zigzag_rle_if #(
  parameter int unsigned COEF_W = 8
) ();
  logic [64*COEF_W-1:0] A;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_run;
  logic [COEF_W:0]      out_level;
  logic                 out_eob;
  logic                 block_done;

  modport slave (
    input  A, in_valid, out_ready,
    output in_ready, out_valid, out_run, out_level, out_eob, block_done
  );

  modport master (
    output A, in_valid, out_ready,
    input  in_ready, out_valid, out_run, out_level, out_eob, block_done
  );
endinterface

// File: rtl/zigzag_rle.sv
// zigzag_rle: scans one quantized 8x8 block in JPEG zig-zag order and emits
// (run, level) symbols with ZRL (15,0) and EOB markers over a valid/ready link.
// Ports:
//   Clock  rising-edge clock
//   reset  asynchronous active-high reset; discards any partial block
//   bus    zigzag_rle_if.slave (block input, symbol output, block_done pulse)
// Build option: define ZIGZAG_RLE_DC_DIFF_EN to code the DC level as the
// difference to the previous accepted DC (prev_DC resets to 0).
module zigzag_rle #(
  parameter int unsigned COEF_W = 8
) (
  input logic         Clock,
  input logic         reset,
  zigzag_rle_if.slave bus
);

  localparam int unsigned BlkW = 64 * COEF_W;
  localparam int unsigned LvlW = COEF_W + 1;

  typedef enum logic [1:0] {StIdle, StScan, StEob, StFin} state_e;

  // Zig-zag index -> raster position (row*8 + col).
  localparam logic [5:0] ZzRaster [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_e            state_q, state_d;
  logic [BlkW-1:0]   blk_q, blk_d;
  logic [5:0]        last_nz_q, last_nz_d;
  logic [5:0]        idx_q, idx_d;
  logic [3:0]        run_q, run_d;
  logic              valid_q, valid_d;
  logic [3:0]        orun_q, orun_d;
  logic [LvlW-1:0]   olvl_q, olvl_d;
  logic              oeob_q, oeob_d;
  logic              done_q, done_d;

`ifdef ZIGZAG_RLE_DC_DIFF_EN
  logic [COEF_W-1:0] prev_dc_q, prev_dc_d;
  logic              is_dc_q, is_dc_d;   // presented symbol is the DC symbol
`endif

  logic [5:0]        last_nz_in;
  logic [COEF_W-1:0] cur_coef;
  logic [LvlW-1:0]   cur_level;
  logic [LvlW-1:0]   dc_level;
  logic              slot_free;
  logic              emit;
  logic [3:0]        emit_run;
  logic [LvlW-1:0]   emit_level;

  // Highest zig-zag index in 1..63 holding a nonzero coefficient of the incoming block.
  always_comb begin
    last_nz_in = '0;
    for (int k = 1; k < 64; k++) begin
      if (bus.A[int'(ZzRaster[k]) * COEF_W +: COEF_W] != '0) begin
        last_nz_in = 6'(k);
      end
    end
  end

  assign cur_coef  = blk_q[int'(ZzRaster[idx_q]) * COEF_W +: COEF_W];
  assign cur_level = {cur_coef[COEF_W-1], cur_coef};

`ifdef ZIGZAG_RLE_DC_DIFF_EN
  // Both operands sign-extended by one bit, so the difference is exact.
  assign dc_level = cur_level - {prev_dc_q[COEF_W-1], prev_dc_q};
`else
  assign dc_level = cur_level;
`endif

  assign slot_free = !valid_q || bus.out_ready;

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    last_nz_d  = last_nz_q;
    idx_d      = idx_q;
    run_d      = run_q;
    valid_d    = valid_q && !bus.out_ready;
    orun_d     = orun_q;
    olvl_d     = olvl_q;
    oeob_d     = oeob_q;
    done_d     = 1'b0;
    emit       = 1'b0;
    emit_run   = '0;
    emit_level = '0;
`ifdef ZIGZAG_RLE_DC_DIFF_EN
    prev_dc_d  = prev_dc_q;
    is_dc_d    = is_dc_q;
    if (valid_q && bus.out_ready && is_dc_q) begin
      prev_dc_d = blk_q[COEF_W-1:0];
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          blk_d     = bus.A;
          last_nz_d = last_nz_in;
          idx_d     = '0;
          run_d     = '0;
          state_d   = StScan;
        end
      end

      StScan: begin
        if (slot_free) begin
          if (idx_q == 6'd0) begin
            emit       = 1'b1;
            emit_level = dc_level;
          end else if (cur_coef != '0) begin
            emit       = 1'b1;
            emit_run   = run_q;
            emit_level = cur_level;
            run_d      = '0;
          end else if (run_q != 4'd15) begin
            run_d = run_q + 4'd1;
          end else begin
            // Sixteenth zero in a row: ZRL
            emit     = 1'b1;
            emit_run = 4'd15;
            run_d    = '0;
          end

          if (emit) begin
            valid_d = 1'b1;
            orun_d  = emit_run;
            olvl_d  = emit_level;
            oeob_d  = 1'b0;
`ifdef ZIGZAG_RLE_DC_DIFF_EN
            is_dc_d = (idx_q == 6'd0);
`endif
          end

          // last_nz == 0 exits right after DC through the same compare.
          if (idx_q == 6'd63) begin
            state_d = StFin;
          end else if (idx_q == last_nz_q) begin
            state_d = StEob;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      StEob: begin
        if (slot_free) begin
          valid_d = 1'b1;
          orun_d  = '0;
          olvl_d  = '0;
          oeob_d  = 1'b1;
`ifdef ZIGZAG_RLE_DC_DIFF_EN
          is_dc_d = 1'b0;
`endif
          state_d = StFin;
        end
      end

      StFin: begin
        // Stay one extra cycle so in_ready rises only after the done pulse.
        if (done_q) begin
          state_d = StIdle;
        end else if (slot_free) begin
          done_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      blk_q     <= '0;
      last_nz_q <= '0;
      idx_q     <= '0;
      run_q     <= '0;
      valid_q   <= 1'b0;
      orun_q    <= '0;
      olvl_q    <= '0;
      oeob_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ZIGZAG_RLE_DC_DIFF_EN
      prev_dc_q <= '0;
      is_dc_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      last_nz_q <= last_nz_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      valid_q   <= valid_d;
      orun_q    <= orun_d;
      olvl_q    <= olvl_d;
      oeob_q    <= oeob_d;
      done_q    <= done_d;
`ifdef ZIGZAG_RLE_DC_DIFF_EN
      prev_dc_q <= prev_dc_d;
      is_dc_q   <= is_dc_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = valid_q;
  assign bus.out_run    = orun_q;
  assign bus.out_level  = olvl_q;
  assign bus.out_eob    = oeob_q;
  assign bus.block_done = done_q;

endmodule

// File: tb/tb_zigzag_rle.sv
// tb_zigzag_rle: directed table-driven bench for zigzag_rle. Each record lists up to
// four nonzero raster coefficients and the expected {eob, run, level} symbol stream.
module tb_zigzag_rle;

`ifdef ZIGZAG_RLE_DC_DIFF_EN
  localparam bit DiffEn = 1'b1;
`else
  localparam bit DiffEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zigzag_rle_if #(.COEF_W(8)) bus ();

  zigzag_rle #(.COEF_W(8)) dut (
    .Clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0][5:0]  pos;
    logic [3:0][7:0]  val;
    logic [3:0]       nsym;
    logic [7:0][13:0] sym;   // {eob, run[3:0], level[8:0]}
  } vec_t;

  localparam int NumVec = 8;
  vec_t vecs [NumVec];

  int          tests = 0;
  int          fails = 0;
  logic [13:0] got [$];
  int          done_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [13:0] hold_sym = '0;
  int          prev_dc_m = 0;

  function automatic logic [13:0] mk(input bit e, input int r, input int l);
    logic [3:0] r4;
    logic [8:0] l9;
    r4 = r[3:0];
    l9 = l[8:0];
    return {e, r4, l9};
  endfunction

  function automatic logic [511:0] build(input vec_t v);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      if (v.val[i] != 8'd0) b[int'(v.pos[i]) * 8 +: 8] = v.val[i];
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: collects accepted symbols, counts done pulses, checks hold-while-stalled.
  initial begin
    logic [13:0] cur;
    forever begin
      @(negedge clk);
      cur = {bus.out_eob, bus.out_run, bus.out_level};
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_sym", 32'(cur), 32'(hold_sym));
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_sym  = cur;
        if (bus.out_valid && bus.out_ready) got.push_back(cur);
        if (bus.block_done) done_cnt++;
      end
    end
  end

  // mode 0: ready high; 1: ready low 3 cycles; 2: ready alternating;
  // 3: ready high with in_valid held and A changed while busy.
  task automatic run_block(input int vi, input int mode, input string tag);
    logic [511:0] blk;
    logic [13:0]  exp;
    logic [13:0]  act;
    int           dc;
    int           cyc;
    bit           done;
    blk = build(vecs[vi]);
    dc  = int'($signed(blk[7:0]));
    got.delete();
    done_cnt = 0;
    bus.out_ready = 1'b1;
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.A        = blk;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    if (mode == 3) begin
      bus.A = {64{8'h11}};
    end else begin
      bus.in_valid = 1'b0;
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      case (mode)
        1:       bus.out_ready = !(cyc >= 3 && cyc < 6);
        2:       bus.out_ready = (cyc % 2) == 1;
        default: bus.out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (bus.block_done) begin
        done = 1'b1;
        bus.in_valid = 1'b0;
        check({tag, "_in_ready_during_done"}, 32'(bus.in_ready), 32'd0);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: block_done not seen within %0d cycles", tag, cyc);
    end else begin
      @(posedge clk); #1;
      check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_done_cleared"}, 32'(bus.block_done), 32'd0);
    end
    bus.out_ready = 1'b1;
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_nsym"}, 32'(got.size()), 32'(vecs[vi].nsym));
    for (int i = 0; i < int'(vecs[vi].nsym); i++) begin
      exp = vecs[vi].sym[i];
      if (i == 0) exp[8:0] = DiffEn ? 9'(dc - prev_dc_m) : 9'(dc);
      act = (i < got.size()) ? got[i] : 14'bx;
      check($sformatf("%s_sym%0d", tag, i), 32'(act), 32'(exp));
    end
    prev_dc_m = dc;
  endtask

  initial begin
    for (int i = 0; i < NumVec; i++) vecs[i] = '0;
    // All-zero block
    vecs[0].nsym = 4'd2;
    vecs[0].sym[0] = mk(0, 0, 0);  vecs[0].sym[1] = mk(1, 0, 0);
    // DC=5, (0,1)=-3, (0,2)=4
    vecs[1].pos[0] = 6'd0;  vecs[1].val[0] = 8'd5;
    vecs[1].pos[1] = 6'd1;  vecs[1].val[1] = 8'hFD;
    vecs[1].pos[2] = 6'd2;  vecs[1].val[2] = 8'd4;
    vecs[1].nsym = 4'd4;
    vecs[1].sym[0] = mk(0, 0, 5);  vecs[1].sym[1] = mk(0, 0, -3);
    vecs[1].sym[2] = mk(0, 3, 4);  vecs[1].sym[3] = mk(1, 0, 0);
    // (5,1)=7 at zig-zag 22
    vecs[2].pos[0] = 6'd41; vecs[2].val[0] = 8'd7;
    vecs[2].nsym = 4'd4;
    vecs[2].sym[0] = mk(0, 0, 0);  vecs[2].sym[1] = mk(0, 15, 0);
    vecs[2].sym[2] = mk(0, 5, 7);  vecs[2].sym[3] = mk(1, 0, 0);
    // DC=1, (7,7)=-1: three ZRLs, no EOB
    vecs[3].pos[0] = 6'd0;  vecs[3].val[0] = 8'd1;
    vecs[3].pos[1] = 6'd63; vecs[3].val[1] = 8'hFF;
    vecs[3].nsym = 4'd5;
    vecs[3].sym[0] = mk(0, 0, 1);   vecs[3].sym[1] = mk(0, 15, 0);
    vecs[3].sym[2] = mk(0, 15, 0);  vecs[3].sym[3] = mk(0, 15, 0);
    vecs[3].sym[4] = mk(0, 14, -1);
    // Extremes: DC=-128, (1,0)=127 at zig-zag 2
    vecs[4].pos[0] = 6'd0;  vecs[4].val[0] = 8'h80;
    vecs[4].pos[1] = 6'd8;  vecs[4].val[1] = 8'h7F;
    vecs[4].nsym = 4'd3;
    vecs[4].sym[0] = mk(0, 0, -128); vecs[4].sym[1] = mk(0, 1, 127);
    vecs[4].sym[2] = mk(1, 0, 0);
    // Adjacent ACs, DC=0
    vecs[5].pos[0] = 6'd1;  vecs[5].val[0] = 8'd1;
    vecs[5].pos[1] = 6'd8;  vecs[5].val[1] = 8'hFF;
    vecs[5].nsym = 4'd4;
    vecs[5].sym[0] = mk(0, 0, 0);  vecs[5].sym[1] = mk(0, 0, 1);
    vecs[5].sym[2] = mk(0, 0, -1); vecs[5].sym[3] = mk(1, 0, 0);
    // DC-only blocks, 10 then 7
    vecs[6].pos[0] = 6'd0;  vecs[6].val[0] = 8'd10;
    vecs[6].nsym = 4'd2;
    vecs[6].sym[0] = mk(0, 0, 10); vecs[6].sym[1] = mk(1, 0, 0);
    vecs[7].pos[0] = 6'd0;  vecs[7].val[0] = 8'd7;
    vecs[7].nsym = 4'd2;
    vecs[7].sym[0] = mk(0, 0, 7);  vecs[7].sym[1] = mk(1, 0, 0);

    rst = 1'b1;
    bus.A = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_run", 32'(bus.out_run), 32'd0);
    check("rst_out_level", 32'(bus.out_level), 32'd0);
    check("rst_out_eob", 32'(bus.out_eob), 32'd0);
    check("rst_block_done", 32'(bus.block_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;

    run_block(0, 0, "zero");
    run_block(1, 0, "dc5");
    run_block(2, 0, "zrl22");
    run_block(3, 0, "last63");
    run_block(2, 1, "bp_stall");
    run_block(1, 2, "bp_alt");
    run_block(4, 3, "busy_ignore");
    run_block(5, 0, "adjacent");

    // Reset in the middle of a long scan.
    @(posedge clk); #1;
    bus.A = build(vecs[3]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_dc_m = 0;
    got.delete();
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_symbols", 32'(got.size()), 32'd0);
    check("midrst_idle", 32'(bus.in_ready), 32'd1);

    run_block(1, 0, "post_rst");
    run_block(6, 0, "dc10");
    run_block(7, 0, "dc7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zigzag_rle.md
Name: zigzag_rle

Overview:
- Downstream neighbour of the quantization stage. Accepts one quantized 8x8 block (64 signed 8-bit coefficients, 512-bit bus) and scans it in JPEG zig-zag order.
- Run-length encodes the scan into a stream of (run, level) symbols, with ZRL and EOB markers.
- Output symbols go to the entropy (Huffman) coder over a valid/ready handshake. Throughput is at most one zig-zag index per clock.

Parameters:
- COEF_W, 8: coefficient width. Block bus width = 64*COEF_W. Level output width = COEF_W+1.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- A  input  512  quantized block; coefficient (row i, col j) at A[(i*8+j)*8 +: 8], two's complement.
- in_valid  input  1  A holds a complete block.
- in_ready  output  1  block can be accepted; high only in IDLE.
- out_valid  output  1  symbol registers hold a valid symbol.
- out_ready  input  1  consumer accepts the symbol this cycle.
- out_run  output  4  zero-run preceding the level (0..15).
- out_level  output  9  signed level, sign-extended from 8 bits.
- out_eob  output  1  current symbol is End-Of-Block.
- block_done  output  1  one-cycle pulse after the final symbol of a block is accepted.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_run=0, out_level=0, out_eob=0, block_done=0.
  - Internal state on reset: scan index=0, run counter=0, FSM=IDLE.
  - Reset mid-block discards the partial block; no further symbols for it.
- FSM states: IDLE, SCAN, EOB, FIN.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge, capture A into the block register.
  - Capture last_nz = highest zig-zag index in 1..63 with a nonzero coefficient, or 0 if none.
  - Clear index and run; go to SCAN.
- Zig-zag order: standard JPEG. Index 0..22 = (0,0)(0,1)(1,0)(2,0)(1,1)(0,2)(0,3)(1,2)(2,1)(3,0)(4,0)(3,1)(2,2)(1,3)(0,4)(0,5)(1,4)(2,3)(3,2)(4,1)(5,0)(6,0)(5,1)... through index 63=(7,7).
- Advance rule: SCAN processes one index per cycle, only when the output slot is free (!out_valid || out_ready). Otherwise it stalls with all state held.
- Per-index action in SCAN:
  - Index 0 (DC): always emit (run=0, level=DC).
  - Index k>0, coefficient nonzero: emit (run, level); run cleared to 0.
  - Index k>0, coefficient zero, run<15: no emit; run+1.
  - Index k>0, coefficient zero, run==15: emit ZRL (run=15, level=0); run cleared to 0.
  - Exit condition, checked after processing the index:
    - index==last_nz and last_nz<63 → EOB state.
    - last_nz==0 after DC → EOB state.
    - index==63 → FIN, with no EOB emitted.
- EOB: when the slot is free, emit (run=0, level=0, out_eob=1); go to FIN.
- FIN: wait until the last symbol is accepted (out_valid && out_ready), then pulse block_done for one cycle and return to IDLE. in_ready rises in the cycle after the block_done pulse.
- Output handshake:
  - A symbol is presented in the cycle after its index is processed.
  - Once out_valid is high, out_run, out_level and out_eob stay stable until out_ready is sampled high.
  - Symbols are never dropped or duplicated.
- in_valid while not in IDLE is ignored.
- Latency: with out_ready tied high, the first symbol (DC) is valid 2 edges after block acceptance.

Optional Feature:
- Macro: ZIGZAG_RLE_DC_DIFF_EN.
- Defined: DC symbol level = DC - prev_DC, a 9-bit signed result that is exact over the 8-bit range.
  - prev_DC updates to the current DC when the DC symbol is accepted.
  - prev_DC resets to 0 on reset.
- Undefined: DC level = raw DC, sign-extended; no prev_DC register.
- AC behaviour is identical in both builds.

Test Plan:
- All-zero block, out_ready=1 → symbols (0,0), then EOB (0,0,eob=1); block_done pulses once; in_ready returns high after it.
- Block with DC=5, (0,1)=-3, (0,2)=4, rest zero → (0,5), (0,-3), (3,4), EOB.
- Only DC=0 and (5,1) [zig-zag 22]=7 nonzero → (0,0), ZRL (15,0), (5,7), EOB.
- DC=1, (7,7)=-1, rest zero → (0,1), three ZRLs, (14,-1); no EOB; block_done pulses after (14,-1) is accepted.
- Backpressure: out_ready=0 for 3 cycles during the block 2 stream → out_run/out_level held stable; same symbol sequence as with out_ready=1.
- Assert reset mid-SCAN → out_valid=0 immediately, in_ready=1. A new block then encodes correctly. With ZIGZAG_RLE_DC_DIFF_EN defined, two blocks with DC=10 then DC=7 give DC levels 10 and -3.
